// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq_pkg
// Purpose  : Shared state encoding and default parameters for reset_sequencer.
// Revision : 1.0
// ============================================================================
package reset_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_WAIT    = 2'd0,
    SEQ_RUNNING = 2'd1,
    SEQ_DONE    = 2'd2
  } seq_state_t;

  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_NUM_DOMAINS = 4;
  localparam int DEF_STRETCH     = 16;

  // One spare bit so the index can step past the last domain without wrapping
  function automatic int idx_width(input int num_domains);
    return $clog2(num_domains) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : reset_sync_chain
// Purpose  : Async-assert / sync-deassert reset synchroniser.
// Revision : 1.0
// ============================================================================
module reset_sync_chain
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = chain_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Releases NUM_DOMAINS reset outputs in order, STRETCH cycles apart.
//            Define RESET_SEQ_SW_REQ_EN to add the sw_req/sw_ack restart port.
// Revision : 1.0
// ============================================================================
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int STRETCH     = DEF_STRETCH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   done
`ifdef RESET_SEQ_SW_REQ_EN
  ,
  input  logic                   sw_req,
  output logic                   sw_ack
`endif
);

  localparam int CNT_W = $clog2(STRETCH + 1);
  localparam int IDX_W = idx_width(NUM_DOMAINS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

  logic                   sync_rst_n;
  seq_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   done_q;
  logic                   sw_rise;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_rst_n (sync_rst_n)
  );

  // The WAIT->SEQ edge is itself the first stretch cycle
  assign cnt_d = (state_q == SEQ_WAIT) ? CNT_W'(1) : cnt_q + CNT_W'(1);

`ifdef RESET_SEQ_SW_REQ_EN
  logic sw_req_q;
  logic sw_ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_req_q <= 1'b0;
      sw_ack_q <= 1'b0;
    end else begin
      sw_req_q <= sw_req;
      sw_ack_q <= sw_rise && (state_q == SEQ_DONE);
    end
  end

  assign sw_rise = sw_req & ~sw_req_q;
  assign sw_ack  = sw_ack_q;
`else
  assign sw_rise = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        SEQ_WAIT, SEQ_RUNNING: begin
          if ((state_q == SEQ_RUNNING) || sync_rst_n) begin
            state_q <= SEQ_RUNNING;
            cnt_q   <= cnt_d;
            if (cnt_d == CNT_LAST) begin
              cnt_q <= '0;
              idx_q <= idx_q + IDX_W'(1);
              for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                  dom_q[i] <= 1'b1;
                end
              end
              if (idx_q == IDX_LAST) begin
                state_q <= SEQ_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        SEQ_DONE: begin
          if (sw_rise) begin
            state_q <= SEQ_RUNNING;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= SEQ_WAIT;
        end
      endcase
    end
  end

  assign dom_rst_n = dom_q;
  assign done      = done_q;

endmodule
`default_nettype wire
